column_ram_writer: RTL and testbench
====================================

# column_ram_writer

Write-side front end of the column RAM. It accepts a 24-bit RGB pixel stream, one slice of 128 pixels at a time, and writes each slice into one half of a ping-pong RAM. It hands the completed half to the framebuffer read path at the framebuffer's end-of-read boundary, and pulses `SOF` so the reader restarts from address 0. It sits between the pixel input deserializer and the framebuffer.

## Interface
Parameters:
- `PIXELS`, 128: pixels per slice (16 rows × 8 mux columns); must be a power of two.
- `ERR_W`, 8: width of the saturating error counters.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `clk_enable`  in  1: global enable. When low, all state holds, except that asynchronous reset still acts.
- `px_data`  in  24: RGB pixel.
- `px_valid`  in  1: `px_data` is valid this cycle.
- `px_sof`  in  1: qualified by `px_valid`; marks the first pixel of a slice.
- `EOR`  in  1: one-cycle pulse from the framebuffer; the read bank has been fully consumed.
- `ram_we`  out  1: RAM write strobe.
- `ram_waddr`  out  8: bit 7 is the bank; bits 6:0 are the pixel address.
- `ram_wdata`  out  24: write data.
- `rd_bank`  out  1: bank the reader must use; this is the MSB of the reader's address.
- `SOF`  out  1: one-cycle pulse; a new bank has been handed to the reader.
- `underrun_cnt`  out  `ERR_W`: saturating count of `EOR` pulses that arrived with no full bank.
- `overflow_cnt`  out  `ERR_W`: saturating count of dropped slices plus short slices.

## Operation
- Pixel addressing: pixel address = arrival index within the slice, row-major, so address = row*8 + col. The reader's stride-8 column read needs no remap.
- `wr_bank` is an internal register. `rd_bank` = ~`wr_bank` at all times.
- The FSM advances only when `clk_enable` is high. States:
  - IDLE: wait for `px_valid & px_sof`. That pixel is written to address 0 and the FSM goes to WRITE with the index set to 1. Pixels without `px_sof` are ignored.
  - WRITE: each `px_valid` pixel is written at the current index, then the index increments.
    - Writing index `PIXELS`-1 moves the FSM to FULL.
    - `px_valid & px_sof` in WRITE restarts the slice: write to address 0, index = 1, `overflow_cnt` +1.
  - FULL: the bank is complete, waiting for the reader.
    - `EOR` causes a swap: `wr_bank` toggles, `SOF` pulses, and the FSM goes to IDLE.
    - `px_valid & px_sof` in FULL drops that entire slice: `overflow_cnt` +1, no writes, state stays FULL.
    - Non-`sof` pixels in FULL are ignored.
- `EOR` in IDLE or WRITE: no swap, `underrun_cnt` +1. The reader re-reads its current bank.
- `EOR` arriving in the same cycle as the last pixel of a slice counts as an underrun. The swap waits for the next `EOR`.
- Simultaneous `EOR` and `px_sof` in FULL: the swap takes priority and the FSM goes to IDLE. The `sof` pixel is then lost, and `overflow_cnt` +1.
- The counters saturate at all-ones and do not wrap.

## Timing
- Reset values: `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `wr_bank`=0 (so `rd_bank`=1), `SOF`=0, both counters 0, state IDLE, index 0.
- Write path: a pixel accepted at cycle t appears as `ram_we`/`ram_waddr`/`ram_wdata` at t+1. `ram_we` is high only for accepted pixels.
- Swap: `EOR` at cycle t in FULL gives `rd_bank` toggled and `SOF`=1 at t+1. `SOF` is low at t+2.
- The last write of a slice is on the RAM port no later than the cycle FULL is entered, so the bank contents are stable before any swap.
- Reset mid-slice or mid-swap discards all progress immediately and returns to the reset values.
- When `clk_enable` is low, `ram_we` and `SOF` are forced to 0 and all state holds.

## Structure
- The shared package `spirose_pkg` holds:
  - `pixel_t` (logic [23:0]),
  - `COL_RAM_DEPTH`=128,
  - `COL_RAM_AW`=7,
  - `MUX_COLS`=8,
  - the `writer_state_t` enum {IDLE, WRITE, FULL}.
- Sub-module `sat_counter` (parameter WIDTH; ports inc, value) is instantiated twice, once for each error counter.

## Test plan
- Reset, then 128 pixels with `px_sof` on pixel 0 and data = index, then `EOR` → writes to addresses 0..127 in bank 0, `SOF` at the `EOR`+1 cycle, `rd_bank`=0.
- `EOR` sent while in WRITE at pixel 40 → no `SOF`, `rd_bank` unchanged, `underrun_cnt`=1; the slice continues to address 127.
- Full slice written, then a second `px_sof` before `EOR` → no RAM writes for the second slice, `overflow_cnt`=1. `EOR` then swaps as normal.
- `px_sof` at pixel 50 of a slice → the next write goes to address 0 in the same bank and `overflow_cnt`=1. The slice completes after 128 more pixels.
- `clk_enable` low for 5 cycles mid-slice with `px_valid` high → no writes and the index holds; resumes at the same address.
- Drive 300 underruns → `underrun_cnt` saturates at 255; reset mid-WRITE → all outputs return to reset values.

Source files
------------

// File: rtl/spirose_pkg.sv
// Shared types and constants for the column RAM write path.
package spirose_pkg;

    typedef logic [23:0] pixel_t;

    localparam int COL_RAM_DEPTH = 128;
    localparam int COL_RAM_AW    = 7;
    localparam int MUX_COLS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } writer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count, holding once saturated.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            value_d = value_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= {WIDTH{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/column_ram_writer.sv
// Writes 128-pixel slices into one half of a ping-pong column RAM and hands
// the finished half to the reader on its end-of-read pulse.
module column_ram_writer
    import spirose_pkg::*;
#(
    parameter int PIXELS = COL_RAM_DEPTH,
    parameter int ERR_W  = 8,
    localparam int AW    = $clog2(PIXELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    input  pixel_t           px_data,
    input  logic             px_valid,
    input  logic             px_sof,
    input  logic             EOR,
    output logic             ram_we,
    output logic [AW:0]      ram_waddr,
    output pixel_t           ram_wdata,
    output logic             rd_bank,
    output logic             SOF,
    output logic [ERR_W-1:0] underrun_cnt,
    output logic [ERR_W-1:0] overflow_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(PIXELS - 1);

    writer_state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          ram_we_q, ram_we_d;
    logic [AW:0]   ram_waddr_q, ram_waddr_d;
    pixel_t        ram_wdata_q, ram_wdata_d;
    logic          sof_q, sof_d;
    logic          sof_pix_s;
    logic          ovf_inc_s;
    logic          und_inc_s;

    assign sof_pix_s = px_valid & px_sof;

    // Slice FSM: write sequencing, bank swap and error detection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_bank_d   = wr_bank_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        sof_d       = 1'b0;
        ovf_inc_s   = 1'b0;
        und_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                und_inc_s = EOR;
                if (sof_pix_s) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = {wr_bank_q, {AW{1'b0}}};
                    ram_wdata_d = px_data;
                    idx_d       = AW'(1);
                    state_d     = WRITE;
                end else begin
                    idx_d = idx_q;
                end
            end
            WRITE: begin
                und_inc_s = EOR;
                if (sof_pix_s) begin
                    // A new slice header mid-slice restarts the bank from 0.
                    ram_we_d    = 1'b1;
                    ram_waddr_d = {wr_bank_q, {AW{1'b0}}};
                    ram_wdata_d = px_data;
                    idx_d       = AW'(1);
                    ovf_inc_s   = 1'b1;
                end else if (px_valid) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = {wr_bank_q, idx_q};
                    ram_wdata_d = px_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {AW{1'b0}};
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                ovf_inc_s = sof_pix_s;
                if (EOR) begin
                    wr_bank_d = ~wr_bank_q;
                    sof_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {AW{1'b0}};
            end
        endcase
    end

    // State and registered RAM-port outputs; everything holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {AW{1'b0}};
            wr_bank_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= {(AW+1){1'b0}};
            ram_wdata_q <= 24'h000000;
            sof_q       <= 1'b0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_bank_q   <= wr_bank_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            sof_q       <= sof_d;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_underrun (
        .clk   (clk),
        .rst   (rst),
        .inc   (clk_enable & und_inc_s),
        .value (underrun_cnt)
    );

    sat_counter #(.WIDTH(ERR_W)) u_overflow (
        .clk   (clk),
        .rst   (rst),
        .inc   (clk_enable & ovf_inc_s),
        .value (overflow_cnt)
    );

    // Strobes are masked while disabled so a held register never re-fires.
    assign ram_we    = ram_we_q & clk_enable;
    assign SOF       = sof_q & clk_enable;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;
    assign rd_bank   = ~wr_bank_q;

endmodule

// File: tb/tb_column_ram_writer.sv
// Directed bench for column_ram_writer with a slice-level reference model
// checked every cycle plus hand-computed spot checks.
module tb_column_ram_writer;

    localparam int PIX = 128;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        clk_enable = 1'b1;
    logic [23:0] px_data    = 24'h0;
    logic        px_valid   = 1'b0;
    logic        px_sof     = 1'b0;
    logic        EOR        = 1'b0;

    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [23:0] ram_wdata;
    logic        rd_bank;
    logic        SOF;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overflow_cnt;

    int total = 0;
    int bad   = 0;

    column_ram_writer #(.PIXELS(PIX), .ERR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_enable   (clk_enable),
        .px_data      (px_data),
        .px_valid     (px_valid),
        .px_sof       (px_sof),
        .EOR          (EOR),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .rd_bank      (rd_bank),
        .SOF          (SOF),
        .underrun_cnt (underrun_cnt),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_fill = -1 waiting for a slice start, 0..PIX pixels stored.
    int          m_fill = -1;
    int          m_bank = 0;
    int          m_und  = 0;
    int          m_ovf  = 0;
    logic        e_we   = 1'b0;
    logic        e_sof  = 1'b0;
    int          e_addr = 0;
    logic [23:0] e_data = 24'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill = -1; m_bank = 0; m_und = 0; m_ovf = 0;
            e_we = 1'b0; e_sof = 1'b0; e_addr = 0; e_data = 24'h0;
        end else if (clk_enable) begin
            e_we  = 1'b0;
            e_sof = 1'b0;
            if (m_fill == PIX) begin
                if (EOR) begin
                    m_bank = 1 - m_bank;
                    e_sof  = 1'b1;
                    m_fill = -1;
                end
                if (px_valid && px_sof && m_ovf < 255) m_ovf++;
            end else begin
                if (EOR && m_und < 255) m_und++;
                if (px_valid && px_sof) begin
                    if (m_fill >= 0 && m_ovf < 255) m_ovf++;
                    e_we = 1'b1; e_addr = m_bank * PIX; e_data = px_data;
                    m_fill = 1;
                end else if (px_valid && m_fill >= 0) begin
                    e_we = 1'b1; e_addr = m_bank * PIX + m_fill; e_data = px_data;
                    m_fill++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ram_we",    32'(ram_we),       32'(clk_enable & e_we));
        chk("SOF",       32'(SOF),          32'(clk_enable & e_sof));
        chk("ram_waddr", 32'(ram_waddr),    32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata),    32'(e_data));
        chk("rd_bank",   32'(rd_bank),      32'(1 - m_bank));
        chk("underrun",  32'(underrun_cnt), 32'(m_und));
        chk("overflow",  32'(overflow_cnt), 32'(m_ovf));
    end

    task automatic drive(input logic v, input logic s, input logic [23:0] d,
                         input logic e, input logic en);
        px_valid = v; px_sof = s; px_data = d; EOR = e; clk_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(ram_we),       32'd0);
        chk({tag, "_waddr"}, 32'(ram_waddr),    32'd0);
        chk({tag, "_wdata"}, 32'(ram_wdata),    32'd0);
        chk({tag, "_sof"},   32'(SOF),          32'd0);
        chk({tag, "_rdb"},   32'(rd_bank),      32'd1);
        chk({tag, "_und"},   32'(underrun_cnt), 32'd0);
        chk({tag, "_ovf"},   32'(overflow_cnt), 32'd0);
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle();

        // Full slice into bank 0, then swap.
        for (int i = 0; i < PIX; i++) begin
            drive(1'b1, i == 0, 24'(i), 1'b0, 1'b1);
            if (i == 0)   chk("t1_first_addr", 32'(ram_waddr), 32'd0);
            if (i == 127) begin
                chk("t1_last_addr", 32'(ram_waddr), 32'd127);
                chk("t1_last_data", 32'(ram_wdata), 32'd127);
            end
        end
        idle();
        drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        chk("t1_sof", 32'(SOF), 32'd1);
        chk("t1_rdb", 32'(rd_bank), 32'd0);
        idle();
        chk("t1_sof_low", 32'(SOF), 32'd0);

        // Underrun at pixel 40 while filling bank 1.
        for (int i = 0; i < PIX; i++) begin
            drive(1'b1, i == 0, 24'h100000 + 24'(i), i == 40, 1'b1);
            if (i == 40) begin
                chk("t2_sof", 32'(SOF), 32'd0);
                chk("t2_rdb", 32'(rd_bank), 32'd0);
                chk("t2_und", 32'(underrun_cnt), 32'd1);
            end
        end
        chk("t2_last_addr", 32'(ram_waddr), 32'd255);

        // Second slice arrives while full: dropped.
        for (int i = 0; i < 11; i++) drive(1'b1, i == 0, 24'h200000 + 24'(i), 1'b0, 1'b1);
        chk("t3_ovf", 32'(overflow_cnt), 32'd1);
        drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        chk("t3_sof", 32'(SOF), 32'd1);
        chk("t3_rdb", 32'(rd_bank), 32'd1);

        // Restart at pixel 50.
        for (int i = 0; i < 50; i++) drive(1'b1, i == 0, 24'h300000 + 24'(i), 1'b0, 1'b1);
        drive(1'b1, 1'b1, 24'h3ABCDE, 1'b0, 1'b1);
        chk("t4_restart_addr", 32'(ram_waddr), 32'd0);
        chk("t4_restart_data", 32'(ram_wdata), 32'h3ABCDE);
        chk("t4_ovf", 32'(overflow_cnt), 32'd2);
        for (int i = 1; i < PIX; i++) drive(1'b1, 1'b0, 24'h310000 + 24'(i), 1'b0, 1'b1);
        chk("t4_last_addr", 32'(ram_waddr), 32'd127);
        drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        chk("t4_rdb", 32'(rd_bank), 32'd0);

        // clk_enable low mid-slice in bank 1.
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 24'h400000 + 24'(i), 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 24'hAA0000 + 24'(k), 1'b0, 1'b0);
            chk("t5_no_we", 32'(ram_we), 32'd0);
        end
        drive(1'b1, 1'b0, 24'h400014, 1'b0, 1'b1);
        chk("t5_resume_addr", 32'(ram_waddr), 32'd148);
        chk("t5_resume_data", 32'(ram_wdata), 32'h400014);
        for (int i = 21; i < PIX; i++) drive(1'b1, 1'b0, 24'h400000 + 24'(i), 1'b0, 1'b1);

        // Swap, then saturate the underrun counter.
        drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        chk("t6_rdb", 32'(rd_bank), 32'd1);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        idle();
        chk("t6_und_sat", 32'(underrun_cnt), 32'd255);

        // Reset in the middle of a slice.
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 24'h500000 + 24'(i), 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // EOR on the last pixel is an underrun; EOR with sof in FULL swaps and drops.
        for (int i = 0; i < PIX; i++) drive(1'b1, i == 0, 24'h600000 + 24'(i), i == 127, 1'b1);
        chk("t7_und", 32'(underrun_cnt), 32'd1);
        idle();
        chk("t7_no_sof", 32'(SOF), 32'd0);
        chk("t7_rdb_hold", 32'(rd_bank), 32'd1);
        drive(1'b1, 1'b1, 24'h6FFFFF, 1'b1, 1'b1);
        chk("t7_sof", 32'(SOF), 32'd1);
        chk("t7_rdb", 32'(rd_bank), 32'd0);
        chk("t7_ovf", 32'(overflow_cnt), 32'd1);
        chk("t7_no_we", 32'(ram_we), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 24'h700000 + 24'(i), 1'b0, 1'b1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
